// File: rtl/fifo_bank4.sv
// Four independent FIFO queues sharing one push port and one pop port.
// Optional FIFO_BANK_BYPASS_EN: a push and a pop to the same empty queue forward data_in straight to data_out.
module fifo_bank4 #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [1:0]            push_id,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [1:0]            pop_id,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic [3:0]            empty,
  output logic [3:0]            full,
  output logic                  error
);

  localparam int unsigned NQ    = 4;
  localparam int unsigned CNT_W = PTR_WIDTH + 1;

  logic [PTR_WIDTH-1:0]  wr_ptr [NQ];
  logic [PTR_WIDTH-1:0]  rd_ptr [NQ];
  logic [CNT_W-1:0]      count  [NQ];
  logic [DATA_WIDTH-1:0] mem    [NQ][DEPTH];

  logic [NQ-1:0] push_hit_c;
  logic [NQ-1:0] pop_hit_c;
  logic [NQ-1:0] wr_ok_c;
  logic [NQ-1:0] rd_ok_c;
  logic [NQ-1:0] bypass_c;
  logic          err_push_c;
  logic          err_pop_c;

  // Per-queue request decode and acceptance.
  for (genvar q = 0; q < NQ; q++) begin : g_queue
    assign push_hit_c[q] = push && (push_id == 2'(q));
    assign pop_hit_c[q]  = pop  && (pop_id  == 2'(q));
    assign empty[q]      = (count[q] == '0);
    assign full[q]       = (count[q] == CNT_W'(DEPTH));
`ifdef FIFO_BANK_BYPASS_EN
    assign bypass_c[q]   = push_hit_c[q] && pop_hit_c[q] && empty[q];
`else
    assign bypass_c[q]   = 1'b0;
`endif
    assign rd_ok_c[q]    = pop_hit_c[q] && !empty[q];
    // A full queue still accepts a push when the same queue is popped this cycle.
    assign wr_ok_c[q]    = push_hit_c[q] && !bypass_c[q] && (!full[q] || pop_hit_c[q]);
  end

  assign err_push_c = |(push_hit_c & full & ~pop_hit_c);
  assign err_pop_c  = |(pop_hit_c & empty & ~bypass_c);

  // Pointer and occupancy registers for all queues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int q = 0; q < NQ; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
        count[q]  <= '0;
      end
    end else begin
      for (int q = 0; q < NQ; q++) begin
        if (wr_ok_c[q]) wr_ptr[q] <= wr_ptr[q] + PTR_WIDTH'(1);
        if (rd_ok_c[q]) rd_ptr[q] <= rd_ptr[q] + PTR_WIDTH'(1);
        if (wr_ok_c[q] && !rd_ok_c[q]) begin
          count[q] <= count[q] + CNT_W'(1);
        end else if (rd_ok_c[q] && !wr_ok_c[q]) begin
          count[q] <= count[q] - CNT_W'(1);
        end
      end
    end
  end

  // Storage is not reset; only pointers define what is live.
  always_ff @(posedge clk) begin
    if (|wr_ok_c) mem[push_id][wr_ptr[push_id]] <= data_in;
  end

  // Registered read port and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      valid    <= 1'b0;
      error    <= 1'b0;
    end else begin
      valid <= |(rd_ok_c | bypass_c);
      if (|rd_ok_c) begin
        data_out <= mem[pop_id][rd_ptr[pop_id]];
      end else if (|bypass_c) begin
        data_out <= data_in;
      end
      if (err_push_c || err_pop_c) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_bank4.sv
// Self-checking bench for fifo_bank4: directed scenarios plus random traffic against a queue-based model.
module tb_fifo_bank4;

  localparam int unsigned DW    = 10;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic [1:0]    push_id;
  logic [DW-1:0] data_in;
  logic          pop;
  logic [1:0]    pop_id;
  logic [DW-1:0] data_out;
  logic          valid;
  logic [3:0]    empty;
  logic [3:0]    full;
  logic          error;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mq [4][$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_err;

  fifo_bank4 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .push(push), .push_id(push_id), .data_in(data_in),
    .pop(pop), .pop_id(pop_id), .data_out(data_out), .valid(valid),
    .empty(empty), .full(full), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_empty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (mq[i].size() == 0);
    return e;
  endfunction

  function automatic logic [3:0] m_full();
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = (mq[i].size() == DEPTH);
    return f;
  endfunction

  task automatic check_all(input string tag);
    tests++;
    assert (data_out === m_dout) else begin
      fails++; $error("FAIL %s data_out got %h expected %h", tag, data_out, m_dout);
    end
    tests++;
    assert (valid === m_valid) else begin
      fails++; $error("FAIL %s valid got %b expected %b", tag, valid, m_valid);
    end
    tests++;
    assert (error === m_err) else begin
      fails++; $error("FAIL %s error got %b expected %b", tag, error, m_err);
    end
    tests++;
    assert (empty === m_empty()) else begin
      fails++; $error("FAIL %s empty got %b expected %b", tag, empty, m_empty());
    end
    tests++;
    assert (full === m_full()) else begin
      fails++; $error("FAIL %s full got %b expected %b", tag, full, m_full());
    end
  endtask

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++; $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock: drive at negedge, update model, check just after the rising edge.
  task automatic step(input logic p, input logic [1:0] pid, input logic [DW-1:0] d,
                      input logic po, input logic [1:0] poid, input string tag);
    logic bypassed;
    push = p; push_id = pid; data_in = d; pop = po; pop_id = poid;
    bypassed = 1'b0;
    m_valid  = 1'b0;
    if (po) begin
      if (mq[poid].size() > 0) begin
        m_dout  = mq[poid].pop_front();
        m_valid = 1'b1;
      end else begin
`ifdef FIFO_BANK_BYPASS_EN
        if (p && pid == poid) begin
          m_dout   = d;
          m_valid  = 1'b1;
          bypassed = 1'b1;
        end else m_err = 1'b1;
`else
        m_err = 1'b1;
`endif
      end
    end
    if (p && !bypassed) begin
      if (mq[pid].size() < DEPTH) mq[pid].push_back(d);
      else m_err = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 2'd0, '0, 1'b0, 2'd0, tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [DW-1:0] v;
    reset = 1'b1; push = 1'b0; push_id = '0; data_in = '0; pop = 1'b0; pop_id = '0;
    model_reset();
    #4 reset = 1'b0;
    #0.5;
    check_all("reset");
    @(negedge clk);

    // Fill and drain queue 2
    for (int i = 1; i <= 4; i++) step(1'b1, 2'd2, DW'(i), 1'b0, 2'd0, "fill_q2");
    check_val("full_q2", DW'(full), DW'(4'b0100));
    check_val("empty_q2", DW'(empty), DW'(4'b1011));
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 2'd0, '0, 1'b1, 2'd2, "drain_q2");
      check_val("drain_q2_word", data_out, DW'(i));
    end
    idle("drain_q2_idle");

    // Pointer wrap on queue 0
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, DW'(10'h0A0 + i), 1'b0, 2'd0, "wrap_push3");
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, '0, 1'b1, 2'd0, "wrap_pop3");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd0, DW'(10'h0B0 + i), 1'b0, 2'd0, "wrap_push4");
      check_val("wrap_full0", DW'(full[0]), DW'(i == 3));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'd0, '0, 1'b1, 2'd0, "wrap_pop4");
      check_val("wrap_order", data_out, DW'(10'h0B0 + i));
    end

    // Round-robin service across all queues
    step(1'b1, 2'd0, 10'h100, 1'b0, 2'd0, "rr_push");
    step(1'b1, 2'd1, 10'h201, 1'b0, 2'd0, "rr_push");
    step(1'b1, 2'd2, 10'h302, 1'b0, 2'd0, "rr_push");
    step(1'b1, 2'd3, 10'h3F3, 1'b0, 2'd0, "rr_push");
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, '0, 1'b1, 2'(i), "rr_pop");
    check_val("rr_empty", DW'(empty), DW'(4'b1111));
    idle("rr_idle");

    // Same-queue push+pop while full: oldest out, newest kept last
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, DW'(10'h050 + i), 1'b0, 2'd0, "sq_fill");
    step(1'b1, 2'd0, 10'h2AA, 1'b1, 2'd0, "sq_full_pp");
    check_val("sq_full_cnt", DW'(full[0]), DW'(1));
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, '0, 1'b1, 2'd0, "sq_drain");
    check_val("sq_last", data_out, 10'h2AA);

    // Same-queue push+pop while empty (bypass or error depending on build)
    step(1'b1, 2'd0, 10'h2AA, 1'b1, 2'd0, "sq_empty_pp");
    idle("sq_empty_idle");
    do_reset();
    check_all("reset2");

    // Error cases: pop empty, push to full
    step(1'b0, 2'd0, '0, 1'b1, 2'd1, "pop_empty");
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'd3, DW'(10'h010 + i), 1'b0, 2'd0, "fill_q3");
    step(1'b1, 2'd3, 10'h155, 1'b0, 2'd0, "push_full");
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, '0, 1'b1, 2'd3, "drain_q3");
    step(1'b0, 2'd0, '0, 1'b1, 2'd3, "drain_q3_extra");

    // Asynchronous reset mid-stream
    do_reset();
    step(1'b1, 2'd1, 10'h111, 1'b0, 2'd0, "pre_async");
    step(1'b1, 2'd2, 10'h222, 1'b1, 2'd1, "pre_async");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b0;

    // Random traffic with a mid-run reset
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      v = DW'($urandom);
      step(($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)), v,
           ($urandom_range(0, 99) < 50), 2'($urandom_range(0, 3)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout waiting for bench completion");
    $fatal(1, "timeout");
  end

endmodule
